// File: rtl/instr_seq_pkg.sv
// Shared types and encodings for the instruction sequencer: FSM states,
// PC source selects and decoder jump classes (package common).
package common;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_REG = 2'd3;

   localparam logic [2:0] J_TYPE_NOP = 3'd0;
   localparam logic [2:0] J_TYPE_J   = 3'd1;
   localparam logic [2:0] J_TYPE_JAL = 3'd2;
   localparam logic [2:0] J_TYPE_JR  = 3'd3;
   localparam logic [2:0] J_TYPE_BEQ = 3'd4;

endpackage

// File: rtl/instr_seq_if.sv
// Instruction-fetch and data-access handshakes between the sequencer and memories.
// A request stays high until the memory answers with ready in the same cycle; the
// transfer completes in the cycle where req and ready are both 1, and req may drop after.
interface instr_seq_if;
   logic imem_req;
   logic imem_ready;
   logic dmem_req;
   logic dmem_ready;
   logic dmem_we;
   logic dmem_re;

   modport master (
      output imem_req, dmem_req, dmem_we, dmem_re,
      input  imem_ready, dmem_ready
   );

   modport slave (
      input  imem_req, dmem_req, dmem_we, dmem_re,
      output imem_ready, dmem_ready
   );
endinterface

// File: rtl/instr_seq_perf_cnt.sv
// Cycle and retired-instruction counters for the sequencer; both wrap modulo 2^CNT_W.
// Instantiated by instr_seq only when SEQ_PERF_CNT_EN is defined.
module seq_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cycle_en,
   input  logic             instr_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instr_q, instr_d;

   always_comb begin
      cycle_d = cycle_q;
      instr_d = instr_q;
      if (cycle_en) cycle_d = cycle_q + CNT_W'(1);
      if (instr_en) instr_d = instr_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb control FSM driving
// datapath strobes. Optional performance counters under SEQ_PERF_CNT_EN.
module instr_seq
   import common::*;
#(
   parameter int DWIDTH = 32,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [2:0]       jump_type,
   input  logic             we_regfile,
   input  logic             we_dmem,
   input  logic             re_dmem,
   input  logic             illegal,
   input  logic             alu_zero,
   instr_seq_if.master      mem,
   output logic             ir_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output state_e           dbg_state
);

   if (DWIDTH < 1 || CNT_W < 1) begin : g_bad_param
      $error("instr_seq: DWIDTH and CNT_W must be positive");
   end

   state_e state_q, state_d;
   logic   imem_req, dmem_req, dmem_we, dmem_re;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      dmem_re  = 1'b0;
      ir_we    = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_SEQ;
      halted   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (mem.imem_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (illegal) begin
               state_d = S_HALT;
            end else if (jump_type != J_TYPE_NOP) begin
               pc_we   = 1'b1;
               state_d = S_FETCH;
               case (jump_type)
                  J_TYPE_J:   pc_sel = PC_JMP;
                  J_TYPE_JAL: begin
                     pc_sel = PC_JMP;
                     rf_we  = 1'b1;
                  end
                  J_TYPE_JR:  pc_sel = PC_REG;
                  J_TYPE_BEQ: pc_sel = alu_zero ? PC_BR : PC_SEQ;
                  default:    pc_sel = PC_SEQ;
               endcase
            end else if (re_dmem || we_dmem) begin
               state_d = S_MEM;
            end else if (we_regfile) begin
               state_d = S_WB;
            end else begin
               pc_we   = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            // A simultaneous read and write request is resolved as a store.
            dmem_req = 1'b1;
            dmem_we  = we_dmem;
            dmem_re  = re_dmem & ~we_dmem;
            if (mem.dmem_ready) begin
               if (we_dmem) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem.imem_req = imem_req;
   assign mem.dmem_req = dmem_req;
   assign mem.dmem_we  = dmem_we;
   assign mem.dmem_re  = dmem_re;
   assign dbg_state    = state_q;

`ifdef SEQ_PERF_CNT_EN
   seq_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .cycle_en  ((state_q != S_IDLE) && (state_q != S_HALT)),
      .instr_en  (pc_we),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_seq.sv
// Directed testbench for instr_seq: state walk, latencies, handshake waits,
// jump resolution, halt and asynchronous reset behaviour.
module tb_instr_seq;
   import common::*;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rstn;
   logic [2:0]       jump_type;
   logic             we_regfile, we_dmem, re_dmem, illegal, alu_zero;
   logic             ir_we, rf_we, pc_we, halted;
   logic [1:0]       pc_sel;
   logic [CNT_W-1:0] cycle_cnt, instr_cnt;
   state_e           dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

   instr_seq_if mem_if ();

   instr_seq #(.DWIDTH(32), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .jump_type  (jump_type),
      .we_regfile (we_regfile),
      .we_dmem    (we_dmem),
      .re_dmem    (re_dmem),
      .illegal    (illegal),
      .alu_zero   (alu_zero),
      .mem        (mem_if),
      .ir_we      (ir_we),
      .rf_we      (rf_we),
      .pc_we      (pc_we),
      .pc_sel     (pc_sel),
      .halted     (halted),
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cnt_exp(input int v);
`ifdef SEQ_PERF_CNT_EN
      return 32'(v);
`else
      return 32'(v * 0);
`endif
   endfunction

   // Inputs change and outputs are sampled mid-cycle, clear of the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_dec(input logic [2:0] jt, input logic wrf, input logic wdm,
                          input logic rdm, input logic ill, input logic az);
      jump_type  = jt;
      we_regfile = wrf;
      we_dmem    = wdm;
      re_dmem    = rdm;
      illegal    = ill;
      alu_zero   = az;
      #1;
   endtask

   task automatic run_lat(output int n);
      n = 1;
      while (pc_we !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic lat_case(input string tag, input logic [2:0] jt, input logic wrf,
                           input logic wdm, input logic rdm, input int exp_lat);
      int n;
      set_dec(jt, wrf, wdm, rdm, 1'b0, 1'b0);
      run_lat(n);
      check(tag, 32'(n), 32'(exp_lat));
      tick();
      check({tag, "_back_to_fetch"}, 32'(dbg_state), 32'(S_FETCH));
   endtask

   task automatic to_exec(input logic [2:0] jt, input logic wrf, input logic wdm,
                          input logic rdm, input logic ill, input logic az);
      set_dec(jt, wrf, wdm, rdm, ill, az);
      tick();
      tick();
   endtask

   initial begin
      rstn = 1'b0;
      mem_if.imem_ready = 1'b1;
      mem_if.dmem_ready = 1'b1;
      set_dec(J_TYPE_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();

      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      check("rst_outs", {ir_we, rf_we, pc_we, halted, mem_if.imem_req, mem_if.dmem_req}, 6'b0);
      check("rst_cycle_cnt", cycle_cnt, 32'd0);
      check("rst_instr_cnt", instr_cnt, 32'd0);
      rstn = 1'b1;
      #1;
      check("idle_outs", {ir_we, pc_we, mem_if.imem_req}, 3'b0);

      // Non-writing ALU op: IDLE, FETCH, DECODE, EXEC, FETCH.
      tick();
      check("c1_state", 32'(dbg_state), 32'(S_FETCH));
      check("c1_ir_we", {mem_if.imem_req, ir_we}, 2'b11);
      tick();
      check("c2_state", 32'(dbg_state), 32'(S_DECODE));
      check("c2_strobes", {ir_we, pc_we, rf_we, mem_if.imem_req}, 4'b0);
      tick();
      check("c3_state", 32'(dbg_state), 32'(S_EXEC));
      check("c3_pc_we", {pc_we, rf_we}, 2'b10);
      check("c3_pc_sel", 32'(pc_sel), 32'(PC_SEQ));
      tick();
      check("c4_state", 32'(dbg_state), 32'(S_FETCH));
      check("c4_cycle_cnt", cycle_cnt, cnt_exp(3));
      check("c4_instr_cnt", instr_cnt, cnt_exp(1));

      // Register-writing ALU op goes through S_WB.
      to_exec(J_TYPE_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("alu_exec_no_pc_we", {pc_we, rf_we}, 2'b00);
      tick();
      check("alu_wb_state", 32'(dbg_state), 32'(S_WB));
      check("alu_wb_strobes", {rf_we, pc_we, 2'(pc_sel)}, {2'b11, PC_SEQ});
      tick();
      check("alu_cycle_cnt", cycle_cnt, cnt_exp(7));
      check("alu_instr_cnt", instr_cnt, cnt_exp(2));

      // Fetch with two wait cycles.
      mem_if.imem_ready = 1'b0;
      #1;
      check("fwait0", {mem_if.imem_req, ir_we}, 2'b10);
      tick();
      check("fwait1", {mem_if.imem_req, ir_we, 3'(dbg_state)}, {2'b10, 3'(S_FETCH)});
      mem_if.imem_ready = 1'b1;
      #1;
      check("fwait_ready", {mem_if.imem_req, ir_we}, 2'b11);
      to_exec(J_TYPE_J, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("j_exec", {pc_we, rf_we, 2'(pc_sel)}, {2'b10, PC_JMP});
      tick();

      // Zero-wait latencies, FETCH entry to pc_we inclusive.
      lat_case("lat_alu",   J_TYPE_NOP, 1'b1, 1'b0, 1'b0, 4);
      lat_case("lat_j",     J_TYPE_J,   1'b0, 1'b0, 1'b0, 3);
      lat_case("lat_jr",    J_TYPE_JR,  1'b0, 1'b0, 1'b0, 3);
      lat_case("lat_beq",   J_TYPE_BEQ, 1'b0, 1'b0, 1'b0, 3);
      lat_case("lat_store", J_TYPE_NOP, 1'b0, 1'b1, 1'b0, 4);
      lat_case("lat_load",  J_TYPE_NOP, 1'b1, 1'b0, 1'b1, 5);

      // Jump resolution.
      to_exec(J_TYPE_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("beq_taken", {pc_we, rf_we, 2'(pc_sel)}, {2'b10, PC_BR});
      tick();
      to_exec(J_TYPE_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("beq_not_taken", {pc_we, rf_we, 2'(pc_sel)}, {2'b10, PC_SEQ});
      tick();
      to_exec(J_TYPE_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("jal", {pc_we, rf_we, 2'(pc_sel)}, {2'b11, PC_JMP});
      tick();
      to_exec(J_TYPE_JR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("jr", {pc_we, rf_we, 2'(pc_sel)}, {2'b10, PC_REG});
      tick();

      // Load with dmem_ready arriving on the fourth S_MEM cycle.
      mem_if.dmem_ready = 1'b0;
      to_exec(J_TYPE_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("lw_exec", {mem_if.dmem_req, pc_we}, 2'b00);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) begin
            mem_if.dmem_ready = 1'b1;
            #1;
         end
         check($sformatf("lw_hold%0d", i),
               {mem_if.dmem_req, mem_if.dmem_re, mem_if.dmem_we, pc_we, rf_we}, 5'b11000);
      end
      tick();
      check("lw_wb", {3'(dbg_state), rf_we, pc_we, mem_if.dmem_req}, {3'(S_WB), 3'b110});
      tick();
      check("lw_released", {3'(dbg_state), mem_if.dmem_req}, {3'(S_FETCH), 1'b0});

      // Read and write both requested: treated as a store.
      to_exec(J_TYPE_NOP, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("st_both", {mem_if.dmem_req, mem_if.dmem_we, mem_if.dmem_re, pc_we, rf_we},
            5'b11010);
      check("st_pc_sel", 32'(pc_sel), 32'(PC_SEQ));
      tick();
      check("st_next", 32'(dbg_state), 32'(S_FETCH));

      // Reset in the middle of a data access.
      mem_if.dmem_ready = 1'b0;
      to_exec(J_TYPE_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      check("mrst_pre", {3'(dbg_state), mem_if.dmem_req}, {3'(S_MEM), 1'b1});
      rstn = 1'b0;
      #1;
      check("mrst_state", 32'(dbg_state), 32'(S_IDLE));
      check("mrst_reqs", {mem_if.dmem_req, mem_if.imem_req, pc_we, rf_we}, 4'b0);
      check("mrst_cycle_cnt", cycle_cnt, 32'd0);
      check("mrst_instr_cnt", instr_cnt, 32'd0);
      tick();
      check("mrst_hold", {3'(dbg_state), pc_we}, {3'(S_IDLE), 1'b0});
      rstn = 1'b1;
      mem_if.dmem_ready = 1'b1;

      // Illegal instruction halts, even with a jump also decoded.
      tick();
      check("halt_fetch", 32'(dbg_state), 32'(S_FETCH));
      to_exec(J_TYPE_JAL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("halt_exec", {pc_we, rf_we, halted}, 3'b000);
      tick();
      for (int i = 0; i < 12; i++) begin
         check($sformatf("halt%0d_state", i), 32'(dbg_state), 32'(S_HALT));
         check($sformatf("halt%0d_outs", i),
               {halted, mem_if.imem_req, mem_if.dmem_req, pc_we, ir_we, rf_we}, 6'b100000);
         check($sformatf("halt%0d_cycle_cnt", i), cycle_cnt, cnt_exp(3));
         tick();
      end
      check("halt_instr_cnt", instr_cnt, 32'd0);
      rstn = 1'b0;
      #1;
      check("unhalt_state", {3'(dbg_state), halted}, {3'(S_IDLE), 1'b0});
      tick();
      rstn = 1'b1;
      tick();
      check("unhalt_fetch", {3'(dbg_state), mem_if.imem_req}, {3'(S_FETCH), 1'b1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
